ddc_agc_ctrl: RTL and testbench
===============================

# ddc_agc_ctrl

Closed-loop gain controller for the DDC AGC datapath. It measures the 15-bit post-AGC I/Q samples over fixed windows and compares the mean magnitude against a programmable target. From that comparison it generates the 17-bit fine gain word `ddc_agc_value` and the 2-bit coarse `ddc_agc_6db_sel` that drive the DDC AGC multiplier and round stage. It sits beside that datapath on the same clock and closes the loop from its outputs back to its gain inputs.

## Interface
- `WIN_LOG2`, 8: measurement window is 2^WIN_LOG2 samples.
- `SETTLE_CYC`, 6: cycles ignored after each gain change. This covers the datapath latency plus margin.
- `STEP_SHIFT`, 5: fine step is g>>STEP_SHIFT, about 0.27 dB.
- `ATTACK_SHIFT`, 2: saturation attack step is g>>ATTACK_SHIFT.
- `LOCK_WINS`, 4: consecutive in-band windows required before lock.
- `GAIN_MIN`, 17'h00100: lowest fine gain allowed at `ddc_agc_6db_sel`=0.
- `ddc_agc_clk` in 1: single clock. One sample per cycle.
- `ddc_agc_rst` in 1: reset is synchronous and active-high.
- `agc_en` in 1: enables the closed loop.
- `agc_manual` in 1: override mode. Outputs follow the manual inputs.
- `agc_manual_value` in 17: manual fine gain.
- `agc_manual_6db_sel` in 2: manual coarse gain.
- `cfg_target` in 16: target mean of |I|+|Q|, unsigned.
- `cfg_hyst` in 16: half-width of the dead band, unsigned.
- `ddc_agc_data_i`, `ddc_agc_data_q` in 15 each: signed samples from the AGC output.
- `ddc_agc_value` out 17: fine gain, unsigned Q1.16. Unity is 17'h10000.
- `ddc_agc_6db_sel` out 2: coarse gain, +6 dB per step.
- `agc_update` out 1: one-cycle pulse whenever either gain output changes.
- `agc_locked` out 1: loop settled inside the dead band.
- `agc_at_limit` out 1: a gain bound was reached. Sticky until the next non-clamped decision.

## Operation
- **Reset values:** `ddc_agc_value`=17'h10000, `ddc_agc_6db_sel`=0, `agc_update`=0, `agc_locked`=0, `agc_at_limit`=0. The FSM resets to IDLE and the accumulator clears.
- **FSM states:** IDLE, MEASURE, DECIDE, SETTLE.
  - IDLE→MEASURE when `agc_en`=1 and `agc_manual`=0.
  - MEASURE→DECIDE after 2^WIN_LOG2 samples.
  - DECIDE→SETTLE if the gain changed, otherwise DECIDE→MEASURE.
  - SETTLE→MEASURE after SETTLE_CYC cycles.
  - `agc_en`=0 or `agc_manual`=1 in any state returns to IDLE next cycle. This aborts the window and discards the accumulator.
- **Measurement:**
  - Per-sample magnitude is |I|+|Q|, 16-bit unsigned. |−16384| is taken as 16384.
  - Accumulator width is 16+WIN_LOG2. Mean M = acc>>WIN_LOG2.
  - `sat_cnt` counts samples where I or Q equals 16383 or −16384.
- **Decision** (18-bit unsigned g' computed from g = `ddc_agc_value`):
  - If `sat_cnt`≠0: g' = g−(g>>ATTACK_SHIFT).
  - Else if M > target+hyst: g' = g−(g>>STEP_SHIFT).
  - Else if M+hyst < target: g' = g+(g>>STEP_SHIFT).
  - Else hold, and the in-band window count increments.
  - Target/hyst sums are computed at 17 bits. There is no wrap.
- **Normalization** (applied in the same DECIDE cycle):
  - g' > 17'h1FFFF and sel<3: sel+1, g=g'>>1.
  - g' > 17'h1FFFF and sel=3: g=17'h1FFFF, `agc_at_limit`=1.
  - g' < 17'h08000 and sel>0: sel−1, g=g'<<1.
  - g' < GAIN_MIN and sel=0: g=GAIN_MIN, `agc_at_limit`=1.
- **Lock:**
  - `agc_locked` sets when the in-band count reaches LOCK_WINS.
  - Any gain change clears the count and `agc_locked`.
  - Entering IDLE also clears both.
- **Manual mode:**
  - Outputs register the manual inputs each cycle. `agc_update` pulses on any change.
  - `agc_locked`=0.
  - On leaving manual mode, the loop starts from the manual values.
- **`agc_en`=0 (not manual):** outputs hold their last values.

## Timing
- DECIDE lasts 1 cycle. Gain outputs and `agc_update` change on the edge that leaves DECIDE.
- In the first window after enable, the gain update is visible 2^WIN_LOG2+2 cycles after the cycle in which `agc_en` is sampled high.
- Samples arriving in SETTLE are ignored.
- If reset is asserted mid-window, all outputs take their reset values on the next edge.

## Structure
- Package `ddc_agc_ctrl_pkg` holds:
  - the state enum;
  - GAIN_UNITY=17'h10000, GAIN_MAX=17'h1FFFF, GAIN_HALF=17'h08000;
  - the sample saturation constants.
- Sub-module `ddc_agc_ctrl_meas` contains the magnitude, accumulator, sample counter and `sat_cnt`. It takes `start`/`abort` inputs and returns `done`, `mean` and `sat`.
- The top level holds the FSM, the decision/normalization logic and the output registers.

## Test plan
All scenarios use defaults, target=8192, hyst=512.
- **Reset:** assert `ddc_agc_rst` for 2 cycles → value=17'h10000, sel=0, all flags 0.
- **Low level:** I=Q=2048 constant, enable → first update at 258 cycles gives value=17'h10800 with a one-cycle `agc_update`.
- **Saturation:** one sample I=16383 in the window, otherwise I=Q=4096 → value=17'h0C000.
- **Promotion:** start in manual at 17'h1F800, sel=0, then release with I=Q=100 → sel=1, value=17'h103E0.
- **Limit:** start at sel=3, value=17'h1FFFF, with I=Q=100 → value stays 17'h1FFFF, `agc_at_limit`=1, no `agc_update`.
- **Lock and abort:** I=Q=4096 (M=8192) for 4 windows → `agc_locked`=1. Then drop `agc_en` mid-window → FSM in IDLE, `agc_locked`=0, outputs held.

Source files
------------

// File: rtl/ddc_agc_ctrl_pkg.sv
// Shared types and constants for the DDC AGC gain controller.
package ddc_agc_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_DECIDE  = 2'd2,
    ST_SETTLE  = 2'd3
  } agc_state_e;

  localparam logic [16:0] GAIN_UNITY = 17'h10000;
  localparam logic [16:0] GAIN_MAX   = 17'h1FFFF;
  localparam logic [16:0] GAIN_HALF  = 17'h08000;

  localparam logic [14:0] SAMP_POS_FS = 15'h3FFF;
  localparam logic [14:0] SAMP_NEG_FS = 15'h4000;

  // |x| of a 15-bit signed sample; -16384 maps to 16384 without overflow.
  function automatic logic [15:0] abs15(input logic [14:0] x);
    logic [15:0] xe;
    xe = {x[14], x};
    return x[14] ? 16'(~xe + 16'd1) : xe;
  endfunction

endpackage

// File: rtl/ddc_agc_ctrl_meas.sv
// Window measurement: accumulates |I|+|Q| over 2^WIN_LOG2 samples and counts full-scale hits.
module ddc_agc_ctrl_meas
  import ddc_agc_ctrl_pkg::*;
#(
  parameter int WIN_LOG2 = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [14:0] samp_i_i,
  input  logic [14:0] samp_q_i,
  output logic        done_o,
  output logic [15:0] mean_o,
  output logic        sat_o
);

  localparam int ACC_W = 16 + WIN_LOG2;
  localparam int SAT_W = WIN_LOG2 + 1;

  logic [ACC_W-1:0]    acc_q;
  logic [WIN_LOG2-1:0] cnt_q;
  logic [SAT_W-1:0]    sat_cnt_q;
  logic                run_q;
  logic                done_q;
  logic [15:0]         mag;
  logic                is_sat;

  assign mag    = abs15(samp_i_i) + abs15(samp_q_i);
  assign is_sat = (samp_i_i == SAMP_POS_FS) || (samp_i_i == SAMP_NEG_FS) ||
                  (samp_q_i == SAMP_POS_FS) || (samp_q_i == SAMP_NEG_FS);

  always_ff @(posedge clk_i) begin
    if (rst_i || abort_i) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      sat_cnt_q <= '0;
      run_q     <= 1'b0;
      done_q    <= 1'b0;
    end else if (start_i) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      sat_cnt_q <= '0;
      run_q     <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (run_q) begin
        acc_q <= acc_q + ACC_W'(mag);
        cnt_q <= cnt_q + WIN_LOG2'(1);
        if (is_sat) sat_cnt_q <= sat_cnt_q + SAT_W'(1);
        // Last sample of the window: freeze the sum so DECIDE sees a stable mean.
        if (&cnt_q) begin
          run_q  <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done_o = done_q;
  assign mean_o = acc_q[ACC_W-1:WIN_LOG2];
  assign sat_o  = |sat_cnt_q;

endmodule

// File: rtl/ddc_agc_ctrl.sv
// Closed-loop AGC controller: measures window mean, steps fine/coarse gain, tracks lock.
module ddc_agc_ctrl
  import ddc_agc_ctrl_pkg::*;
#(
  parameter int          WIN_LOG2     = 8,
  parameter int          SETTLE_CYC   = 6,
  parameter int          STEP_SHIFT   = 5,
  parameter int          ATTACK_SHIFT = 2,
  parameter int          LOCK_WINS    = 4,
  parameter logic [16:0] GAIN_MIN     = 17'h00100
) (
  input  logic        ddc_agc_clk,
  input  logic        ddc_agc_rst,
  input  logic        agc_en,
  input  logic        agc_manual,
  input  logic [16:0] agc_manual_value,
  input  logic [1:0]  agc_manual_6db_sel,
  input  logic [15:0] cfg_target,
  input  logic [15:0] cfg_hyst,
  input  logic [14:0] ddc_agc_data_i,
  input  logic [14:0] ddc_agc_data_q,
  output logic [16:0] ddc_agc_value,
  output logic [1:0]  ddc_agc_6db_sel,
  output logic        agc_update,
  output logic        agc_locked,
  output logic        agc_at_limit
);

  localparam int SET_W = $clog2(SETTLE_CYC + 1);
  localparam int LCK_W = $clog2(LOCK_WINS + 1);

  agc_state_e  state_q, state_d;
  logic [SET_W-1:0] settle_q, settle_d;
  logic [LCK_W-1:0] inb_q, inb_d;
  logic [16:0] value_q, value_d;
  logic [1:0]  sel_q, sel_d;
  logic        update_q, update_d, locked_q, locked_d, limit_q, limit_d;

  logic        meas_start, meas_abort, meas_done, meas_sat;
  logic [15:0] meas_mean;
  logic [16:0] hi_thr, lo_sum, n_val;
  logic [17:0] g_ext, g_new;
  logic [1:0]  n_sel;
  logic        in_band, clamp, changed;

  ddc_agc_ctrl_meas #(.WIN_LOG2(WIN_LOG2)) u_meas (
    .clk_i    (ddc_agc_clk),
    .rst_i    (ddc_agc_rst),
    .start_i  (meas_start),
    .abort_i  (meas_abort),
    .samp_i_i (ddc_agc_data_i),
    .samp_q_i (ddc_agc_data_q),
    .done_o   (meas_done),
    .mean_o   (meas_mean),
    .sat_o    (meas_sat)
  );

  // Gain step decision followed by coarse/fine renormalization.
  always_comb begin
    g_ext   = {1'b0, value_q};
    hi_thr  = {1'b0, cfg_target} + {1'b0, cfg_hyst};
    lo_sum  = {1'b0, meas_mean} + {1'b0, cfg_hyst};
    in_band = 1'b0;
    if (meas_sat)                         g_new = g_ext - (g_ext >> ATTACK_SHIFT);
    else if ({1'b0, meas_mean} > hi_thr)  g_new = g_ext - (g_ext >> STEP_SHIFT);
    else if (lo_sum < {1'b0, cfg_target}) g_new = g_ext + (g_ext >> STEP_SHIFT);
    else begin
      g_new   = g_ext;
      in_band = 1'b1;
    end

    n_val = g_new[16:0];
    n_sel = sel_q;
    clamp = 1'b0;
    if (g_new > {1'b0, GAIN_MAX}) begin
      if (sel_q != 2'd3) begin
        n_sel = sel_q + 2'd1;
        n_val = g_new[17:1];
      end else begin
        n_val = GAIN_MAX;
        clamp = 1'b1;
      end
    end else if (g_new < {1'b0, GAIN_HALF} && sel_q != 2'd0) begin
      n_sel = sel_q - 2'd1;
      n_val = {g_new[15:0], 1'b0};
    end else if (g_new < {1'b0, GAIN_MIN} && sel_q == 2'd0) begin
      n_val = GAIN_MIN;
      clamp = 1'b1;
    end
    changed = (n_val != value_q) || (n_sel != sel_q);
  end

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    inb_d    = inb_q;
    value_d  = value_q;
    sel_d    = sel_q;
    update_d = 1'b0;
    locked_d = locked_q;
    limit_d  = limit_q;

    case (state_q)
      ST_IDLE:    if (agc_en && !agc_manual) state_d = ST_MEASURE;
      ST_MEASURE: if (meas_done) state_d = ST_DECIDE;
      ST_DECIDE: begin
        value_d  = n_val;
        sel_d    = n_sel;
        limit_d  = clamp;
        update_d = changed;
        if (changed) begin
          inb_d    = '0;
          locked_d = 1'b0;
          settle_d = SET_W'(SETTLE_CYC - 1);
          state_d  = ST_SETTLE;
        end else begin
          state_d = ST_MEASURE;
          if (in_band) begin
            if (inb_q != LCK_W'(LOCK_WINS)) inb_d = inb_q + LCK_W'(1);
            if (inb_d == LCK_W'(LOCK_WINS)) locked_d = 1'b1;
          end
        end
      end
      ST_SETTLE: begin
        if (settle_q == '0) state_d = ST_MEASURE;
        else                settle_d = settle_q - SET_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase

    // Disable or override wins over any in-flight decision; gains hold.
    if (!agc_en || agc_manual) begin
      state_d  = ST_IDLE;
      inb_d    = '0;
      locked_d = 1'b0;
      value_d  = value_q;
      sel_d    = sel_q;
      limit_d  = limit_q;
      update_d = 1'b0;
    end
    if (agc_manual) begin
      value_d  = agc_manual_value;
      sel_d    = agc_manual_6db_sel;
      update_d = (agc_manual_value != value_q) || (agc_manual_6db_sel != sel_q);
    end
  end

  assign meas_start = (state_d == ST_MEASURE) && (state_q != ST_MEASURE);
  assign meas_abort = (state_d == ST_IDLE);

  always_ff @(posedge ddc_agc_clk) begin
    if (ddc_agc_rst) begin
      state_q  <= ST_IDLE;
      settle_q <= '0;
      inb_q    <= '0;
      value_q  <= GAIN_UNITY;
      sel_q    <= 2'd0;
      update_q <= 1'b0;
      locked_q <= 1'b0;
      limit_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      inb_q    <= inb_d;
      value_q  <= value_d;
      sel_q    <= sel_d;
      update_q <= update_d;
      locked_q <= locked_d;
      limit_q  <= limit_d;
    end
  end

  assign ddc_agc_value   = value_q;
  assign ddc_agc_6db_sel = sel_q;
  assign agc_update      = update_q;
  assign agc_locked      = locked_q;
  assign agc_at_limit    = limit_q;

endmodule

// File: tb/tb_ddc_agc_ctrl.sv
// Scoreboard bench for ddc_agc_ctrl: expected gain updates are queued, a monitor checks each pulse.
module tb_ddc_agc_ctrl;
  import ddc_agc_ctrl_pkg::*;

  logic        clk;
  logic        rst;
  logic        en;
  logic        man;
  logic [16:0] man_val;
  logic [1:0]  man_sel;
  logic [15:0] tgt;
  logic [15:0] hyst;
  logic [14:0] di;
  logic [14:0] dq;
  logic [16:0] ddc_agc_value;
  logic [1:0]  ddc_agc_6db_sel;
  logic        agc_update;
  logic        agc_locked;
  logic        agc_at_limit;

  ddc_agc_ctrl dut (
    .ddc_agc_clk        (clk),
    .ddc_agc_rst        (rst),
    .agc_en             (en),
    .agc_manual         (man),
    .agc_manual_value   (man_val),
    .agc_manual_6db_sel (man_sel),
    .cfg_target         (tgt),
    .cfg_hyst           (hyst),
    .ddc_agc_data_i     (di),
    .ddc_agc_data_q     (dq),
    .ddc_agc_value      (ddc_agc_value),
    .ddc_agc_6db_sel    (ddc_agc_6db_sel),
    .agc_update         (agc_update),
    .agc_locked         (agc_locked),
    .agc_at_limit       (agc_at_limit)
  );

  typedef struct {
    logic [16:0] val;
    logic [1:0]  sel;
    int          at;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Every agc_update pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (agc_update === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_update: value %h sel %0d at cycle %0d, none expected",
                 ddc_agc_value, ddc_agc_6db_sel, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (ddc_agc_value !== e.val || ddc_agc_6db_sel !== e.sel || (e.at >= 0 && cyc != e.at)) begin
          errors++;
          $display("FAIL update: got value %h sel %0d cycle %0d, expected value %h sel %0d cycle %0d",
                   ddc_agc_value, ddc_agc_6db_sel, cyc, e.val, e.sel, e.at);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [16:0] v, input logic [1:0] s, input int at);
    exp_t e;
    e.val = v;
    e.sel = s;
    e.at  = at;
    sb.push_back(e);
  endtask

  task automatic wait_sb(input string name, input int budget);
    int k;
    k = 0;
    while (sb.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d updates still pending after %0d cycles, required 0", name, sb.size(), budget);
      sb.delete();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b0;
    man = 1'b0;
    cycles(2);
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0; man = 1'b0; man_val = '0; man_sel = '0;
    tgt = 16'd8192; hyst = 16'd512; di = '0; dq = '0;

    // Reset values
    cycles(2);
    rst = 1'b0;
    cycles(1);
    chk("rst_value",  32'(ddc_agc_value),   32'h10000);
    chk("rst_sel",    32'(ddc_agc_6db_sel), 32'h0);
    chk("rst_update", 32'(agc_update),      32'h0);
    chk("rst_locked", 32'(agc_locked),      32'h0);
    chk("rst_limit",  32'(agc_at_limit),    32'h0);

    // Manual override, then reset mid-window
    push(17'h12345, 2'd2, -1);
    man_val = 17'h12345; man_sel = 2'd2; man = 1'b1; en = 1'b1;
    wait_sb("manual_set", 5);
    chk("manual_locked", 32'(agc_locked), 32'h0);
    di = 15'd2048; dq = 15'd2048;
    man = 1'b0;
    cycles(100);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_value", 32'(ddc_agc_value),   32'h10000);
    chk("midrst_sel",   32'(ddc_agc_6db_sel), 32'h0);
    chk("midrst_state", 32'(dut.state_q),     32'(ST_IDLE));
    en = 1'b0;
    cycles(1);
    rst = 1'b0;

    // Low level: M=4096 below band, one up-step after 258 cycles
    do_reset();
    di = 15'd2048; dq = 15'd2048;
    @(negedge clk);
    push(17'h10800, 2'd0, cyc + 1 + 258);
    en = 1'b1;
    wait_sb("low_level", 300);
    chk("low_locked", 32'(agc_locked),   32'h0);
    chk("low_limit",  32'(agc_at_limit), 32'h0);

    // Saturation: one full-scale sample forces the attack step
    do_reset();
    di = 15'd4096; dq = 15'd4096;
    @(negedge clk);
    push(17'h0C000, 2'd0, cyc + 1 + 258);
    en = 1'b1;
    cycles(60);
    di = 15'h3FFF;
    cycles(1);
    di = 15'd4096;
    wait_sb("saturation", 300);
    chk("sat_limit", 32'(agc_at_limit), 32'h0);

    // Promotion into the next coarse step
    do_reset();
    push(17'h1F800, 2'd0, -1);
    man_val = 17'h1F800; man_sel = 2'd0; man = 1'b1; en = 1'b1;
    wait_sb("promo_manual", 5);
    di = 15'd100; dq = 15'd100;
    @(negedge clk);
    push(17'h103E0, 2'd1, cyc + 1 + 258);
    man = 1'b0;
    wait_sb("promotion", 300);

    // Upper limit: clamp, flag, no update
    do_reset();
    push(17'h1FFFF, 2'd3, -1);
    man_val = 17'h1FFFF; man_sel = 2'd3; man = 1'b1; en = 1'b1;
    wait_sb("limit_manual", 5);
    di = 15'd100; dq = 15'd100;
    man = 1'b0;
    cycles(100);
    chk("limit_pre", 32'(agc_at_limit), 32'h0);
    cycles(165);
    chk("limit_flag",  32'(agc_at_limit),    32'h1);
    chk("limit_value", 32'(ddc_agc_value),   32'h1FFFF);
    chk("limit_sel",   32'(ddc_agc_6db_sel), 32'h3);

    // Lock after four in-band windows, then abort mid-window
    do_reset();
    di = 15'd4096; dq = 15'd4096;
    @(negedge clk);
    en = 1'b1;
    cycles(3 * 258 + 4);
    chk("lock_after3", 32'(agc_locked), 32'h0);
    cycles(258);
    chk("lock_after4", 32'(agc_locked), 32'h1);
    cycles(100);
    en = 1'b0;
    cycles(2);
    chk("abort_state",  32'(dut.state_q),     32'(ST_IDLE));
    chk("abort_locked", 32'(agc_locked),      32'h0);
    chk("abort_value",  32'(ddc_agc_value),   32'h10000);
    chk("abort_sel",    32'(ddc_agc_6db_sel), 32'h0);
    en = 1'b1;
    cycles(260);
    chk("relock_count_cleared", 32'(agc_locked), 32'h0);
    en = 1'b0;
    cycles(5);
    chk("tail_no_pending", 32'(sb.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
